// File: rtl/wb_sequencer.sv
// Write-back sequencer for the multicycle MIPS register file: performs the post-reset
// $sp init write, then serves one write-back request at a time with a ready timeout.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_INIT     | reset state; next edge drives the $sp init write
// S_INIT_END | init write in flight; next edge clears it and sets init_done
// S_IDLE     | waiting for wb_req
// S_WAIT     | request latched; polling src_ready[src_q] with timeout
// S_WRITE    | write/ack cycle in flight; next edge returns to idle
// S_ERR      | abort pulse in flight; next edge returns to idle
module wb_sequencer #(
    parameter int unsigned TIMEOUT = 16,   // legal 1..255
    parameter int unsigned SP_ADDR = 29
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wb_req,
    input  logic [2:0] wb_src,
    input  logic [4:0] wb_dst,
    input  logic [5:0] src_ready,
    output logic [2:0] mux_sel,
    output logic       reg_write,
    output logic [4:0] reg_addr,
    output logic       wb_busy,
    output logic       wb_ack,
    output logic       wb_err,
    output logic       init_done
);

    typedef enum logic [2:0] {
        S_INIT, S_INIT_END, S_IDLE, S_WAIT, S_WRITE, S_ERR
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] SEL_SP   = 3'd6;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [2:0] src_q, src_nxt;
    logic [4:0] dst_q, dst_nxt;
    logic [2:0] mux_sel_nxt;
    logic [4:0] reg_addr_nxt;
    logic       reg_write_nxt, wb_busy_nxt, wb_ack_nxt, wb_err_nxt, init_done_nxt;
    logic [7:0] ready_ext;
    logic       ready_sel;

    // Widened so the 3-bit source code indexes in range.
    assign ready_ext = {2'b00, src_ready};
    assign ready_sel = ready_ext[src_q];

    // Outputs are registered: each value below is what the output shows after this edge.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        src_nxt       = src_q;
        dst_nxt       = dst_q;
        mux_sel_nxt   = 3'd0;
        reg_addr_nxt  = 5'd0;
        reg_write_nxt = 1'b0;
        wb_ack_nxt    = 1'b0;
        wb_err_nxt    = 1'b0;
        wb_busy_nxt   = wb_busy;
        init_done_nxt = init_done;
        case (state)
            S_INIT: begin
                mux_sel_nxt   = SEL_SP;
                reg_addr_nxt  = 5'(SP_ADDR);
                reg_write_nxt = 1'b1;
                state_nxt     = S_INIT_END;
            end
            S_INIT_END: begin
                init_done_nxt = 1'b1;
                state_nxt     = S_IDLE;
            end
            S_IDLE: begin
                if (wb_req) begin
                    src_nxt     = wb_src;
                    dst_nxt     = wb_dst;
                    wb_busy_nxt = 1'b1;
                    if (wb_src >= 3'd6) begin
                        wb_err_nxt = 1'b1;
                        state_nxt  = S_ERR;
                    end else begin
                        cnt_nxt   = 8'd0;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ready_sel) begin
                    mux_sel_nxt   = src_q;
                    reg_addr_nxt  = dst_q;
                    reg_write_nxt = (dst_q != 5'd0);
                    wb_ack_nxt    = 1'b1;
                    state_nxt     = S_WRITE;
                end else if (cnt == CNT_LAST) begin
                    wb_err_nxt = 1'b1;
                    state_nxt  = S_ERR;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_WRITE, S_ERR: begin
                wb_busy_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_INIT;
            cnt       <= 8'd0;
            src_q     <= 3'd0;
            dst_q     <= 5'd0;
            mux_sel   <= 3'd0;
            reg_addr  <= 5'd0;
            reg_write <= 1'b0;
            wb_busy   <= 1'b0;
            wb_ack    <= 1'b0;
            wb_err    <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            src_q     <= src_nxt;
            dst_q     <= dst_nxt;
            mux_sel   <= mux_sel_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_write <= reg_write_nxt;
            wb_busy   <= wb_busy_nxt;
            wb_ack    <= wb_ack_nxt;
            wb_err    <= wb_err_nxt;
            init_done <= init_done_nxt;
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: each request's outcome (ack edge or abort edge) is predicted
// from the ready delay and timeout, then every cycle's outputs are compared.
module tb_wb_sequencer;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wb_req = 1'b0;
    logic [2:0] wb_src = 3'd0;
    logic [4:0] wb_dst = 5'd0;
    logic [5:0] src_ready = 6'd0;
    logic [2:0] mux_sel;
    logic       reg_write;
    logic [4:0] reg_addr;
    logic       wb_busy, wb_ack, wb_err, init_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_sequencer #(.TIMEOUT(TIMEOUT), .SP_ADDR(29)) dut (
        .clk(clk), .reset_n(reset_n), .wb_req(wb_req), .wb_src(wb_src),
        .wb_dst(wb_dst), .src_ready(src_ready), .mux_sel(mux_sel),
        .reg_write(reg_write), .reg_addr(reg_addr), .wb_busy(wb_busy),
        .wb_ack(wb_ack), .wb_err(wb_err), .init_done(init_done)
    );

    // {init_done, busy, ack, err, reg_write, mux_sel, reg_addr}
    logic [12:0] obs;
    assign obs = {init_done, wb_busy, wb_ack, wb_err, reg_write, mux_sel, reg_addr};

    function automatic logic [12:0] pack(input bit done, input bit busy, input bit ack,
                                         input bit err, input bit wr,
                                         input logic [2:0] ms, input logic [4:0] ra);
        return {done, busy, ack, err, wr, ms, ra};
    endfunction

    task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got done/busy/ack/err/wr/sel/addr=%b required %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset (possibly mid-operation), then the $sp init write; a request held during
    // init must not be accepted.
    task automatic do_init();
        reset_n = 1'b0;
        #3;
        check_eq("reset_clear", obs, 13'd0);
        wb_req = 1'b1;
        wb_src = 3'($urandom_range(0, 5));
        wb_dst = 5'($urandom);
        src_ready = 6'h3f;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_eq("init_sp_write", obs, pack(0, 0, 0, 0, 1, 3'd6, 5'd29));
        tick();
        check_eq("init_done", obs, pack(1, 0, 0, 0, 0, 3'd0, 5'd0));
        wb_req = 1'b0;
        tick();
        check_eq("idle_after_init", obs, pack(1, 0, 0, 0, 0, 3'd0, 5'd0));
    endtask

    // d = number of WAIT edges that see src_ready low before it rises.
    task automatic run_req(input logic [2:0] src, input logic [4:0] dst, input int d,
                           input int gap);
        int  e;
        bit  is_ack;
        logic [12:0] exp;
        logic [5:0]  rdy;
        if (src >= 3'd6) begin
            e = 0; is_ack = 1'b0;
        end else if (d < TIMEOUT) begin
            e = d + 1; is_ack = 1'b1;
        end else begin
            e = TIMEOUT; is_ack = 1'b0;
        end
        wb_req = 1'b1;
        wb_src = src;
        wb_dst = dst;
        src_ready = 6'($urandom);
        tick();
        for (int k = 0; k <= e; k++) begin
            if (k < e)
                exp = pack(1, 1, 0, 0, 0, 3'd0, 5'd0);
            else if (is_ack)
                exp = pack(1, 1, 1, 0, dst != 5'd0, src, dst);
            else
                exp = pack(1, 1, 0, 1, 0, 3'd0, 5'd0);
            check_eq($sformatf("req_s%0d_d%0d_k%0d", src, d, k), obs, exp);
            rdy = 6'($urandom);
            if (src < 3'd6) rdy[src] = (k >= d);
            src_ready = rdy;
            if (k == e) wb_req = 1'b0;
            tick();
        end
        check_eq("req_done_idle", obs, pack(1, 0, 0, 0, 0, 3'd0, 5'd0));
        for (int g = 0; g < gap; g++) begin
            tick();
            check_eq("gap_idle", obs, pack(1, 0, 0, 0, 0, 3'd0, 5'd0));
        end
    endtask

    initial begin
        do_init();
        run_req(3'd0, 5'd8, 0, 0);
        run_req(3'd1, 5'd5, 3, 1);
        run_req(3'd2, 5'd11, 100, 0);
        run_req(3'd7, 5'd9, 0, 0);
        run_req(3'd6, 5'd1, 0, 1);
        run_req(3'd3, 5'd0, 2, 0);
        run_req(3'd4, 5'd31, TIMEOUT - 1, 0);
        run_req(3'd5, 5'd17, TIMEOUT, 0);
        for (int i = 0; i < 40; i++)
            run_req(3'($urandom_range(0, 7)), 5'($urandom), $urandom_range(0, 20),
                    $urandom_range(0, 2));

        // Abort mid-WAIT with reset; the dropped request must produce no ack/err.
        wb_req = 1'b1;
        wb_src = 3'd2;
        wb_dst = 5'd12;
        src_ready = 6'd0;
        tick();
        check_eq("pre_reset_accept", obs, pack(1, 1, 0, 0, 0, 3'd0, 5'd0));
        tick();
        tick();
        check_eq("pre_reset_wait", obs, pack(1, 1, 0, 0, 0, 3'd0, 5'd0));
        do_init();
        run_req(3'd1, 5'd3, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Register-file write-back sequencer for the multicycle MIPS datapath. It owns the 3-bit select of the write-data multiplexer, the register-file write enable and the destination address. After reset it performs one automatic write of the stack-pointer initial value (mux code 6, constant 227) to $29. It then serves one write-back request at a time, waiting for the selected source to become valid, with a timeout.

## Interface
- TIMEOUT, 16: WAIT cycles allowed before abort; legal range 1..255.
- SP_ADDR, 29: register written during the post-reset init write.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- wb_req  input  1  write-back request (level); sampled only in IDLE.
- wb_src  input  3  write-data mux source code; 0..5 legal, 6..7 illegal from requesters.
- wb_dst  input  5  destination register number.
- src_ready  input  6  per-source data-valid flags; bit i qualifies mux input i.
- mux_sel  output  3  select to the write-data multiplexer.
- reg_write  output  1  register-file write enable.
- reg_addr  output  5  register-file write address.
- wb_busy  output  1  high while a request is in flight (WAIT/WRITE/ERR).
- wb_ack  output  1  one-cycle pulse: write-back completed.
- wb_err  output  1  one-cycle pulse: request aborted (illegal source or timeout).
- init_done  output  1  high once the $sp init write has completed; stays high until reset.

## Operation
- Reset is asynchronous. While reset_n is low, state is INIT and all outputs are registered 0, including init_done.
- Outputs are registered and change only on clk rising edges.
- INIT, first edge after reset release:
  - Drive mux_sel=3'b110, reg_addr=SP_ADDR, reg_write=1 for one cycle.
  - Go to INIT_END.
- INIT_END:
  - Clear all outputs and set init_done=1.
  - Go to IDLE.
- IDLE: on an edge with wb_req=1:
  - Latch src_q=wb_src and dst_q=wb_dst, and set wb_busy=1.
  - If wb_src ≥ 6, go to ERR. Otherwise clear cnt and go to WAIT.
  - With wb_req=0, hold IDLE.
- WAIT: each edge samples src_ready[src_q].
  - If 1: go to WRITE. Drive mux_sel=src_q, reg_addr=dst_q and wb_ack=1. Drive reg_write=1 only if dst_q≠0; $0 writes are suppressed but still acked.
  - If 0: cnt increments.
  - When cnt reaches TIMEOUT−1 with src_ready still 0, go to ERR with no write.
  - cnt is 8 bits wide and never wraps: the exit to ERR precedes overflow.
- WRITE: next edge clears reg_write, wb_ack, mux_sel and reg_addr to 0, clears wb_busy, and goes to IDLE.
- ERR: wb_err=1 for one cycle. Next edge clears wb_err and wb_busy and goes to IDLE. reg_write is never asserted from ERR.
- mux_sel, reg_addr and reg_write are 0 in every state except INIT and WRITE.
- Requester handshake:
  - Hold wb_req, wb_src and wb_dst stable until wb_ack or wb_err is seen.
  - Deassert wb_req in that cycle.
  - Inputs are latched at acceptance; later changes are ignored.

## Timing
- Reset release → $sp write cycle: 1 edge. → init_done=1: 2 edges.
- Requests asserted before init_done are not accepted; state is not IDLE yet.
- src_ready is never sampled on the acceptance edge. If it is high at acceptance, the minimum path is one WAIT edge.
- Minimum request latency:
  - Edge0 accept.
  - Edge1 ready seen; reg_write/wb_ack high in cycle 1.
  - Edge2: busy low, back in IDLE.
  - Earliest next acceptance: edge3.
- Timeout path: exactly TIMEOUT WAIT edges, then wb_err for one cycle.
- Illegal source: wb_err high in the cycle after acceptance.
- reset_n low mid-operation: immediate clear to INIT with outputs 0. The in-flight request is dropped with no ack and no err. The $sp init write repeats after release.
- Throughput: at most one write-back per 3 cycles.

## Test plan
- Release reset → cycle 1: mux_sel=6, reg_addr=29, reg_write=1; cycle 2: all 0, init_done=1.
- Req src=0, dst=8, src_ready=6'b000001 held → reg_write=1, mux_sel=0, reg_addr=8, wb_ack=1 one cycle after acceptance; busy low one cycle later.
- Req src=1, dst=5, src_ready[1] rising after 3 WAIT cycles → write occurs on the 4th WAIT edge; no wb_err.
- Req src=2, src_ready=0, TIMEOUT=16 → wb_err pulse after 16 WAIT edges; reg_write never high.
- Req src=7 → wb_err the cycle after acceptance, no write. Req src=3, dst=0 → wb_ack=1 with reg_write=0.
- reset_n low during WAIT → outputs 0 immediately; after release, $sp init write repeats, and no ack or err for the dropped request.
